// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline interlock/flush controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW   = 5;
  localparam int unsigned SB_DEPTH = 3;
  localparam int unsigned CNT_W    = 2;
  localparam int unsigned STAT_W   = 32;

  localparam int unsigned STG_EX  = 0;
  localparam int unsigned STG_MEM = 1;
  localparam int unsigned STG_WB  = 2;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dst;
  } sb_entry_t;

endpackage

// File: rtl/hazard_scoreboard.sv
// Three-entry destination scoreboard (EX, MEM, WB) with RAW match and stall-count lookup.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush,
  input  logic              bubble,
  input  logic              regwrite,
  input  logic [REG_AW-1:0] dst,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              use_rs,
  input  logic              use_rt,
  output logic              hazard_c,
  output logic [CNT_W-1:0]  count_c
);

  sb_entry_t entries [SB_DEPTH];

  // Shift register; a flush kills EX and MEM but lets the branch retire into WB.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(SB_DEPTH); i++) entries[i] <= '0;
    end else begin
      entries[STG_WB] <= entries[STG_MEM];
      if (flush) begin
        entries[STG_MEM] <= '0;
        entries[STG_EX]  <= '0;
      end else begin
        entries[STG_MEM]      <= entries[STG_EX];
        entries[STG_EX].valid <= !bubble && regwrite && (dst != '0);
        entries[STG_EX].dst   <= bubble ? '0 : dst;
      end
    end
  end

  // Scan oldest to youngest so the youngest match sets the largest count.
  always_comb begin
    hazard_c = 1'b0;
    count_c  = '0;
    for (int i = int'(SB_DEPTH) - 1; i >= 0; i--) begin
      if (entries[i].valid &&
          ((use_rs && (rs != '0) && (entries[i].dst == rs)) ||
           (use_rt && (rt != '0) && (entries[i].dst == rt)))) begin
        hazard_c = 1'b1;
        count_c  = CNT_W'(int'(SB_DEPTH) - i);
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage interlock and branch flush controller for the 5-stage pipeline.
// Define HAZARD_CTRL_STATS_EN to add saturating stall/flush cycle counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_regwrite_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              mem_br_taken_i,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              ifid_flush_o,
  output logic              idex_bubble_o,
  output logic              exmem_flush_o,
  output logic              stall_o
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cycles_o,
  output logic [STAT_W-1:0] flush_cycles_o
`endif
);

  state_e            state;
  logic [CNT_W-1:0]  cnt;
  logic              hazard_c;
  logic [CNT_W-1:0]  count_c;
  logic              flush_c;
  logic              stall_c;

  assign flush_c = mem_br_taken_i;
  assign stall_c = (state == ST_STALL) || hazard_c;

  hazard_scoreboard u_sb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush    (flush_c),
    .bubble   (stall_c),
    .regwrite (id_regwrite_i),
    .dst      (id_dst_i),
    .rs       (id_rs_i),
    .rt       (id_rt_i),
    .use_rs   (id_use_rs_i),
    .use_rt   (id_use_rt_i),
    .hazard_c (hazard_c),
    .count_c  (count_c)
  );

  // cnt holds the STALL cycles still owed after the detecting RUN cycle.
  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_c) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hazard_c && (count_c > CNT_W'(1))) begin
            state <= ST_STALL;
            cnt   <= count_c - CNT_W'(1);
          end
        end
        ST_STALL: begin
          if (cnt <= CNT_W'(1)) begin
            state <= ST_RUN;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= ST_RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // A taken branch overrides the interlock: everything younger is squashed.
  always_comb begin
    stall_o       = stall_c;
    pc_write_o    = flush_c || !stall_c;
    ifid_write_o  = flush_c || !stall_c;
    ifid_flush_o  = flush_c;
    idex_bubble_o = flush_c || stall_c;
    exmem_flush_o = flush_c;
  end

`ifdef HAZARD_CTRL_STATS_EN
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cycles_o <= '0;
      flush_cycles_o <= '0;
    end else begin
      if (stall_c && !flush_c && (stall_cycles_o != '1))
        stall_cycles_o <= stall_cycles_o + STAT_W'(1);
      if (flush_c && (flush_cycles_o != '1))
        flush_cycles_o <= flush_cycles_o + STAT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed hazard/flush/reset cases plus random traffic.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] rs = '0, rt = '0, dst = '0;
  logic       use_rs = 1'b0, use_rt = 1'b0, regwrite = 1'b0, br = 1'b0;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, exmem_flush, stall;
`ifdef HAZARD_CTRL_STATS_EN
  logic [31:0] stall_cycles, flush_cycles;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: per-stage {valid,dst} (0=EX,1=MEM,2=WB) and stall cycles still owed.
  bit         m_valid [3];
  logic [4:0] m_dst   [3];
  int         owed = 0;
  int         exp_stall_cnt = 0;
  int         exp_flush_cnt = 0;
  logic       obs_stall;

  hazard_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs_i        (rs),
    .id_rt_i        (rt),
    .id_use_rs_i    (use_rs),
    .id_use_rt_i    (use_rt),
    .id_regwrite_i  (regwrite),
    .id_dst_i       (dst),
    .mem_br_taken_i (br),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .exmem_flush_o  (exmem_flush),
    .stall_o        (stall)
`ifdef HAZARD_CTRL_STATS_EN
    ,
    .stall_cycles_o (stall_cycles),
    .flush_cycles_o (flush_cycles)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  // Stall cycles owed by a consumer reading (rs_v, rt_v): 3 if youngest producer in EX, 2 MEM, 1 WB.
  function automatic int model_count(input logic [4:0] rs_v, input logic [4:0] rt_v,
                                     input bit urs, input bit urt);
    for (int s = 0; s < 3; s++) begin
      if (m_valid[s] && ((urs && rs_v != 0 && m_dst[s] == rs_v) ||
                         (urt && rt_v != 0 && m_dst[s] == rt_v)))
        return 3 - s;
    end
    return 0;
  endfunction

  task automatic step(input logic r, input logic [4:0] rs_v, input logic [4:0] rt_v,
                      input bit urs, input bit urt, input bit rw, input logic [4:0] d,
                      input bit b);
    int  c;
    bit  es;
    @(negedge clk);
    rst = r; rs = rs_v; rt = rt_v; use_rs = urs; use_rt = urt;
    regwrite = rw; dst = d; br = b;
    #1;
    obs_stall = stall;
    c  = model_count(rs_v, rt_v, urs, urt);
    es = (owed > 0) || (c > 0);
    if (r) begin
      chk("stall",       32'(stall),       32'(es));
      chk("pc_write",    32'(pc_write),    32'(b || !es));
      chk("ifid_write",  32'(ifid_write),  32'(b || !es));
      chk("ifid_flush",  32'(ifid_flush),  32'(b));
      chk("idex_bubble", 32'(idex_bubble), 32'(b || es));
      chk("exmem_flush", 32'(exmem_flush), 32'(b));
`ifdef HAZARD_CTRL_STATS_EN
      chk("stall_cycles", stall_cycles, 32'(exp_stall_cnt));
      chk("flush_cycles", flush_cycles, 32'(exp_flush_cnt));
`endif
    end
    @(posedge clk);
    if (!r) begin
      for (int s = 0; s < 3; s++) begin m_valid[s] = 0; m_dst[s] = '0; end
      owed = 0; exp_stall_cnt = 0; exp_flush_cnt = 0;
    end else begin
      if (es && !b) exp_stall_cnt++;
      if (b) exp_flush_cnt++;
      m_valid[2] = m_valid[1]; m_dst[2] = m_dst[1];
      if (b) begin
        m_valid[1] = 0; m_valid[0] = 0;
        owed = 0;
      end else begin
        m_valid[1] = m_valid[0]; m_dst[1] = m_dst[0];
        m_valid[0] = !es && rw && (d != 0); m_dst[0] = d;
        owed = (owed > 0) ? owed - 1 : ((c > 0) ? c - 1 : 0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
  endtask

  task automatic producer(input logic [4:0] d);
    step(1, 5'd0, 5'd0, 0, 0, 1, d, 0);
  endtask

  task automatic filler();
    step(1, 5'd7, 5'd8, 1, 1, 1, 5'd9, 0);
  endtask

  // Hold a consumer in ID until it issues; returns number of stalled cycles.
  task automatic consumer(input logic [4:0] rs_v, input logic [4:0] rt_v, output int n);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      step(1, rs_v, rt_v, 1, 1, 1, 5'd2, 0);
      if (!obs_stall) break;
      n++;
    end
  endtask

  initial begin
    int n;
    for (int s = 0; s < 3; s++) begin m_valid[s] = 0; m_dst[s] = '0; end
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
    idle(2);

    // Back-to-back dependent pair: producer in EX.
    producer(5'd1); consumer(5'd1, 5'd3, n); chk("dep_ex_stalls", 32'(n), 32'd3);
    idle(3);
    // Producer in MEM.
    producer(5'd1); filler(); consumer(5'd1, 5'd3, n); chk("dep_mem_stalls", 32'(n), 32'd2);
    idle(3);
    // Producer in WB.
    producer(5'd1); filler(); filler(); consumer(5'd3, 5'd1, n); chk("dep_wb_stalls", 32'(n), 32'd1);
    idle(3);
    // Writes to $0 never interlock.
    producer(5'd0); consumer(5'd0, 5'd0, n); chk("r0_stalls", 32'(n), 32'd0);
    idle(3);
    // rs hits MEM, rt hits EX: youngest governs.
    producer(5'd1); producer(5'd4); consumer(5'd1, 5'd4, n); chk("both_hit_stalls", 32'(n), 32'd3);
    idle(3);

    // Taken branch in the last stall cycle, then no residual stall.
    producer(5'd1);
    step(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 0);
    step(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 0);
    step(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 1);
    step(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 0);
    chk("post_flush_stall", 32'(obs_stall), 32'd0);
    idle(3);
    // Branch in the first STALL cycle: producer retires into WB, one more stall remains.
    producer(5'd1);
    step(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 0);
    step(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 1);
    step(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 0);
    chk("flush_wb_keep_stall", 32'(obs_stall), 32'd1);
    idle(3);

    // Reset in the middle of a stall aborts it.
    producer(5'd1);
    step(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 0);
    step(0, 5'd1, 5'd3, 1, 1, 1, 5'd2, 0);
    step(1, 5'd1, 5'd3, 1, 1, 1, 5'd2, 0);
    chk("post_reset_stall", 32'(obs_stall), 32'd0);
    idle(3);

    // Random traffic on a small register window to provoke hazards.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(63) != 0),
           5'($urandom_range(3)), 5'($urandom_range(3)),
           bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(1)),
           5'($urandom_range(3)), ($urandom_range(7) == 0));
    end
    idle(3);

`ifdef HAZARD_CTRL_STATS_EN
    step(0, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0);
    producer(5'd1); consumer(5'd1, 5'd3, n); idle(3);
    producer(5'd5); consumer(5'd3, 5'd5, n); idle(3);
    step(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 1);
    idle(1);
    chk("stats_stall_total", stall_cycles, 32'd6);
    chk("stats_flush_total", flush_cycles, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
